// File: rtl/fetch_decode_regs.sv
// rtl/fetch_decode_regs.sv - Y86-64 F/D pipeline registers and fetch PC select
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module fetch_decode_regs #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [3:0]        W_icode,
  input  logic [ADDR_W-1:0] W_valM,
  input  logic [2:0]        f_stat,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic [ADDR_W-1:0] f_predPC,
  output logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] F_predPC,
  output logic [2:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [ADDR_W-1:0] D_valC,
  output logic [ADDR_W-1:0] D_valP
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_f_stall_cnt,
  output logic [CNT_W-1:0]  perf_d_bubble_cnt,
  output logic [CNT_W-1:0]  perf_fetch_cnt
`endif
);

  localparam logic [2:0] SAOK     = 3'd1;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] R_NONE   = 4'hF;

  // A not-taken jump reaching M means the taken prediction was wrong.
  always_comb begin
    f_pc = F_predPC;
    if (M_icode == I_JXX && !M_Cnd)
      f_pc = M_valA;
    else if (W_icode == I_RET)
      f_pc = W_valM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      F_predPC <= '0;
    else if (!F_stall)
      F_predPC <= f_predPC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (!D_stall && D_bubble)) begin
      D_stat  <= SAOK;
      D_icode <= I_NOP;
      D_ifun  <= 4'h0;
      D_rA    <= R_NONE;
      D_rB    <= R_NONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      D_stat  <= f_stat;
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_rA;
      D_rB    <= f_rB;
      D_valC  <= f_valC;
      D_valP  <= f_valP;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_f_stall_cnt  <= '0;
      perf_d_bubble_cnt <= '0;
      perf_fetch_cnt    <= '0;
    end else begin
      if (F_stall && perf_f_stall_cnt != CNT_MAX)
        perf_f_stall_cnt <= perf_f_stall_cnt + 1'b1;
      if (D_bubble && !D_stall && perf_d_bubble_cnt != CNT_MAX)
        perf_d_bubble_cnt <= perf_d_bubble_cnt + 1'b1;
      if (!D_stall && !D_bubble && f_icode != I_NOP && perf_fetch_cnt != CNT_MAX)
        perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_regs.sv
// tb/tb_fetch_decode_regs.sv - self-checking bench for fetch_decode_regs
// Perf counter checks are built when PIPE_PERF_CNT_EN is defined.
module tb_fetch_decode_regs;
  localparam int AW = 64;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n, F_stall, D_stall, D_bubble, M_Cnd;
  logic [3:0] M_icode, W_icode, f_icode, f_ifun, f_rA, f_rB;
  logic [2:0] f_stat;
  logic [AW-1:0] M_valA, W_valM, f_valC, f_valP, f_predPC;
  logic [AW-1:0] f_pc, F_predPC, D_valC, D_valP;
  logic [2:0] D_stat;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] perf_f_stall_cnt, perf_d_bubble_cnt, perf_fetch_cnt;
`endif

  fetch_decode_regs #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM), .f_stat(f_stat), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC),
    .f_valP(f_valP), .f_predPC(f_predPC), .f_pc(f_pc), .F_predPC(F_predPC),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA),
    .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
`ifdef PIPE_PERF_CNT_EN
    , .perf_f_stall_cnt(perf_f_stall_cnt), .perf_d_bubble_cnt(perf_d_bubble_cnt),
    .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the F and D registers as plain values plus event counts.
  typedef struct {
    logic [2:0] stat; logic [3:0] icode, ifun, ra, rb; logic [AW-1:0] valc, valp;
  } dreg_t;
  localparam dreg_t BUBBLE = '{stat: 3'd1, icode: 4'd1, ifun: 4'd0, ra: 4'hF, rb: 4'hF, valc: '0, valp: '0};

  bit m_valid = 0;
  logic [AW-1:0] m_f;
  dreg_t m_d;
  int m_fs, m_db, m_fc;
  int cmax = (1 << CW) - 1;

  function automatic logic [AW-1:0] exp_pc();
    if (M_icode == 4'd7 && M_Cnd == 1'b0) return M_valA;
    if (W_icode == 4'd9) return W_valM;
    return m_f;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_f = '0; m_d = BUBBLE; m_fs = 0; m_db = 0; m_fc = 0;
    end else if (m_valid) begin
      if (F_stall) m_fs = (m_fs < cmax) ? m_fs + 1 : cmax;
      if (D_bubble && !D_stall) m_db = (m_db < cmax) ? m_db + 1 : cmax;
      if (!D_stall && !D_bubble && f_icode != 4'd1) m_fc = (m_fc < cmax) ? m_fc + 1 : cmax;
      if (!F_stall) m_f = f_predPC;
      if (!D_stall)
        m_d = D_bubble ? BUBBLE : '{stat: f_stat, icode: f_icode, ifun: f_ifun,
                                    ra: f_rA, rb: f_rB, valc: f_valC, valp: f_valP};
    end
  end

  // Compare process: every negedge once the model has seen a reset edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("f_pc", f_pc, exp_pc());
      chk("F_predPC", F_predPC, m_f);
      chk("D_stat", {61'd0, D_stat}, {61'd0, m_d.stat});
      chk("D_icode", {60'd0, D_icode}, {60'd0, m_d.icode});
      chk("D_ifun", {60'd0, D_ifun}, {60'd0, m_d.ifun});
      chk("D_rA", {60'd0, D_rA}, {60'd0, m_d.ra});
      chk("D_rB", {60'd0, D_rB}, {60'd0, m_d.rb});
      chk("D_valC", D_valC, m_d.valc);
      chk("D_valP", D_valP, m_d.valp);
`ifdef PIPE_PERF_CNT_EN
      chk("perf_f_stall_cnt", AW'(perf_f_stall_cnt), AW'(m_fs));
      chk("perf_d_bubble_cnt", AW'(perf_d_bubble_cnt), AW'(m_db));
      chk("perf_fetch_cnt", AW'(perf_fetch_cnt), AW'(m_fc));
`endif
    end
  end

  task automatic rand_f();
    f_stat = 3'($urandom_range(1, 4)); f_icode = 4'($urandom); f_ifun = 4'($urandom);
    f_rA = 4'($urandom); f_rB = 4'($urandom);
    f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom}; f_predPC = {$urandom, $urandom};
  endtask

  task automatic quiet();
    F_stall = 0; D_stall = 0; D_bubble = 0; M_icode = 4'd0; M_Cnd = 0; W_icode = 4'd0;
    M_valA = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
  endtask

  // Advance one edge; returns 2 time units after it.
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  initial begin
    rst_n = 0; quiet(); rand_f();
    cyc(); rand_f(); cyc();
    chk("rst F_predPC", F_predPC, 64'h0);
    chk("rst D_icode", {60'd0, D_icode}, 64'd1);
    chk("rst D_stat", {61'd0, D_stat}, 64'd1);
    chk("rst D_rA", {60'd0, D_rA}, 64'hF);
    chk("rst D_valC", D_valC, 64'h0);

    rst_n = 1; rand_f(); f_predPC = 64'h14; cyc();
    chk("rel F_predPC", F_predPC, 64'h14);

    f_icode = 4'd3; f_rB = 4'd2; f_valC = 64'h100; f_valP = 64'hA; f_predPC = 64'hA; cyc();
    chk("flow D_icode", {60'd0, D_icode}, 64'd3);
    chk("flow D_valC", D_valC, 64'h100);
    chk("flow F_predPC", F_predPC, 64'hA);
    #1 chk("flow f_pc", f_pc, 64'hA);

    F_stall = 1; D_stall = 1;
    for (int i = 0; i < 2; i++) begin rand_f(); cyc(); end
    chk("stall F_predPC", F_predPC, 64'hA);
    chk("stall D_valC", D_valC, 64'h100);
    F_stall = 0; D_stall = 0; rand_f(); f_icode = 4'd6; f_predPC = 64'h80; cyc();
    chk("unstall D_icode", {60'd0, D_icode}, 64'd6);

    M_icode = 4'd7; M_Cnd = 0; M_valA = 64'h40; D_bubble = 1; F_stall = 1; rand_f();
    #1 chk("mispredict f_pc", f_pc, 64'h40);
    cyc();
    chk("mispredict D_icode", {60'd0, D_icode}, 64'd1);
    M_Cnd = 1;
    #1 chk("taken f_pc", f_pc, 64'h80);
    cyc();

    quiet(); F_stall = 1; D_bubble = 1; W_icode = 4'd9; W_valM = 64'h200; rand_f();
    #1 chk("ret f_pc", f_pc, 64'h200);
    cyc();
    chk("ret F_predPC", F_predPC, 64'h80);
    chk("ret D_rB", {60'd0, D_rB}, 64'hF);
    M_icode = 4'd7; M_Cnd = 0; M_valA = 64'h44;
    #1 chk("prio f_pc", f_pc, 64'h44);
    cyc();

    quiet(); rand_f(); f_icode = 4'd5; f_valP = 64'h77; cyc();
    D_stall = 1; D_bubble = 1; rand_f(); cyc();
    chk("stall+bubble D_icode", {60'd0, D_icode}, 64'd5);
    chk("stall+bubble D_valP", D_valP, 64'h77);

`ifdef PIPE_PERF_CNT_EN
    quiet(); rst_n = 0; cyc(); rst_n = 1; F_stall = 1;
    for (int i = 0; i < 3; i++) cyc();
    chk("perf 3 stalls", AW'(perf_f_stall_cnt), 64'd3);
    for (int i = 0; i < 20; i++) cyc();
    chk("perf saturate", AW'(perf_f_stall_cnt), 64'd15);
`endif

    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      F_stall = ($urandom_range(0, 3) == 0); D_stall = ($urandom_range(0, 3) == 0);
      D_bubble = ($urandom_range(0, 3) == 0);
      M_icode = ($urandom_range(0, 2) == 0) ? 4'd7 : 4'($urandom);
      M_Cnd = 1'($urandom); W_icode = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom);
      M_valA = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      rand_f();
      if ($urandom_range(0, 3) == 0) f_icode = 4'd1;
      cyc();
    end

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
